// File: rtl/dummy_accelerator_pkg.sv
// Shared types for the dummy accelerator: the ctl encoding, issue-buffer entry and FSM state.
// Used by the issue buffer (DUMMY_ACC_ISSUE_BYPASS_EN selects its optional bypass path).
package dummy_accelerator_pkg;

  typedef enum logic {
    EU_CTL_ITERATIVE = 1'b0,
    EU_CTL_PIPELINE  = 1'b1
  } ctl_type_t;

  localparam int IB_WIDTH     = 32;
  localparam int IB_IMM_WIDTH = 11;
  localparam int IB_TAG_WIDTH = 5;

  typedef struct packed {
    ctl_type_t                 ctl;
    logic [IB_WIDTH-1:0]       rs1;
    logic [IB_IMM_WIDTH-1:0]   imm;
    logic [IB_TAG_WIDTH-1:0]   tag;
  } ib_entry_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } ib_state_e;

endpackage

// File: rtl/dummy_accelerator_ib_fifo.sv
// Generic DEPTH-entry FIFO of issue-buffer entries with wrap-bit pointers.
// Push is refused when full and pop when empty; flush clears the pointers only.
module dummy_accelerator_ib_fifo
  import dummy_accelerator_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = ib_entry_t
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   flush_i,
  input  logic   push_i,
  input  entry_t wdata_i,
  input  logic   pop_i,
  output entry_t rdata_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  entry_t        mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  always_comb begin
    empty_o = (wr_ptr_q == rd_ptr_q);
    full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    rdata_o  = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Storage is zeroed on reset so the head data outputs read 0 afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/dummy_accelerator_issue_buffer.sv
// Issue buffer in front of the dummy accelerator: never mixes iterative and pipelined work in flight.
// Define DUMMY_ACC_ISSUE_BYPASS_EN to let a request reach the accelerator in its arrival cycle.
module dummy_accelerator_issue_buffer
  import dummy_accelerator_pkg::*;
#(
  parameter int WIDTH        = IB_WIDTH,
  parameter int IMM_WIDTH    = IB_IMM_WIDTH,
  parameter int TAG_WIDTH    = IB_TAG_WIDTH,
  parameter int DEPTH        = 4,
  parameter int MAX_INFLIGHT = 100
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              flush_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  input  ctl_type_t                         ctl_i,
  input  logic [WIDTH-1:0]                  rs1_value_i,
  input  logic [IMM_WIDTH-1:0]              imm_i,
  input  logic [TAG_WIDTH-1:0]              tag_i,
  output logic                              acc_valid_o,
  input  logic                              acc_ready_i,
  output ctl_type_t                         acc_ctl_o,
  output logic [WIDTH-1:0]                  acc_rs1_value_o,
  output logic [IMM_WIDTH-1:0]              acc_imm_o,
  output logic [TAG_WIDTH-1:0]              acc_tag_o,
  input  logic                              acc_done_i,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_o,
  output logic                              empty_o,
  output logic                              full_o,
  output ib_state_e                         state_o
);

  // Handshakes: a transfer happens in a cycle where valid and ready are both high;
  // valid never depends on ready and, once raised, holds with stable data until it transfers.

  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  typedef struct packed {
    ctl_type_t            ctl;
    logic [WIDTH-1:0]     rs1;
    logic [IMM_WIDTH-1:0] imm;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  ib_state_e       state_q, state_d;
  logic [IW-1:0]   inflight_q, inflight_d;
  ctl_type_t       cur_ctl_q, cur_ctl_d;

  entry_t          in_entry;
  entry_t          head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            fire;
  logic            eligible;
  logic            bypass_ok;
  logic            done_dec;
  logic            room;

  assign in_entry = '{ctl: ctl_i, rs1: rs1_value_i, imm: imm_i, tag: tag_i};

  dummy_accelerator_ib_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .wdata_i (in_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    room     = (inflight_q < IW'(MAX_INFLIGHT));
    eligible = !fifo_empty && room && ((inflight_q == '0) || (head.ctl == cur_ctl_q));
`ifdef DUMMY_ACC_ISSUE_BYPASS_EN
    // The FIFO is empty here, so there is no older request to overtake.
    bypass_ok = fifo_empty && (state_q != S_DRAIN) && valid_i && room &&
                ((inflight_q == '0) || (ctl_i == cur_ctl_q));
`else
    bypass_ok = 1'b0;
`endif
  end

  // FSM output process: issue valid and the data presented to the accelerator.
  always_comb begin
    acc_valid_o = (eligible && (state_q != S_DRAIN)) || bypass_ok;
    if (bypass_ok) begin
      acc_ctl_o       = in_entry.ctl;
      acc_rs1_value_o = in_entry.rs1;
      acc_imm_o       = in_entry.imm;
      acc_tag_o       = in_entry.tag;
    end else begin
      acc_ctl_o       = head.ctl;
      acc_rs1_value_o = head.rs1;
      acc_imm_o       = head.imm;
      acc_tag_o       = head.tag;
    end
  end

  always_comb begin
    fire       = acc_valid_o && acc_ready_i && !flush_i;
    pop        = fire && !bypass_ok;
    push       = valid_i && !fifo_full && !flush_i && !(bypass_ok && acc_ready_i);
    done_dec   = acc_done_i && (inflight_q != '0);
    inflight_d = inflight_q + IW'(fire) - IW'(done_dec);
    cur_ctl_d  = fire ? acc_ctl_o : cur_ctl_q;
  end

  // FSM next-state process; transitions look at the post-update in-flight count so a
  // drained head issues in the cycle right after the last completion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (fire) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (inflight_d == '0) state_d = S_IDLE;
        else if (!fifo_empty && !fire && (head.ctl != cur_ctl_q)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (inflight_d == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register with in-flight tracking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      inflight_q <= '0;
      cur_ctl_q  <= EU_CTL_ITERATIVE;
    end else if (flush_i) begin
      state_q    <= S_IDLE;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      cur_ctl_q  <= cur_ctl_d;
    end
  end

  assign ready_o    = !fifo_full;
  assign empty_o    = fifo_empty;
  assign full_o     = fifo_full;
  assign inflight_o = inflight_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_dummy_accelerator_issue_buffer.sv
// Self-checking bench for the issue buffer: directed scenarios plus a random run
// against a queue-based reference model (bypass scenario when DUMMY_ACC_ISSUE_BYPASS_EN is set).
module tb_dummy_accelerator_issue_buffer;
  import dummy_accelerator_pkg::*;

  localparam int WIDTH = 32;
  localparam int IMM_WIDTH = 11;
  localparam int TAG_WIDTH = 5;
  localparam int DEPTH = 4;
  localparam int MAX_INFLIGHT = 100;
  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  logic                 clk;
  logic                 rst_i;
  logic                 flush_i;
  logic                 valid_i;
  logic                 ready_o;
  ctl_type_t            ctl_i;
  logic [WIDTH-1:0]     rs1_value_i;
  logic [IMM_WIDTH-1:0] imm_i;
  logic [TAG_WIDTH-1:0] tag_i;
  logic                 acc_valid_o;
  logic                 acc_ready_i;
  ctl_type_t            acc_ctl_o;
  logic [WIDTH-1:0]     acc_rs1_value_o;
  logic [IMM_WIDTH-1:0] acc_imm_o;
  logic [TAG_WIDTH-1:0] acc_tag_o;
  logic                 acc_done_i;
  logic [IW-1:0]        inflight_o;
  logic                 empty_o;
  logic                 full_o;
  ib_state_e            state_o;

  int tests = 0;
  int fails = 0;

  dummy_accelerator_issue_buffer #(
    .WIDTH(WIDTH), .IMM_WIDTH(IMM_WIDTH), .TAG_WIDTH(TAG_WIDTH),
    .DEPTH(DEPTH), .MAX_INFLIGHT(MAX_INFLIGHT)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .ctl_i(ctl_i), .rs1_value_i(rs1_value_i), .imm_i(imm_i), .tag_i(tag_i),
    .acc_valid_o(acc_valid_o), .acc_ready_i(acc_ready_i), .acc_ctl_o(acc_ctl_o),
    .acc_rs1_value_o(acc_rs1_value_o), .acc_imm_o(acc_imm_o), .acc_tag_o(acc_tag_o),
    .acc_done_i(acc_done_i), .inflight_o(inflight_o), .empty_o(empty_o), .full_o(full_o),
    .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    ctl_type_t            ctl;
    logic [WIDTH-1:0]     rs1;
    logic [IMM_WIDTH-1:0] imm;
    logic [TAG_WIDTH-1:0] tag;
  } m_entry_t;

  m_entry_t  exp_q[$];
  int        m_inflight = 0;
  ctl_type_t m_cur = EU_CTL_ITERATIVE;

  function automatic bit model_elig();
    if (exp_q.size() == 0) return 1'b0;
    if (m_inflight >= MAX_INFLIGHT) return 1'b0;
    return (m_inflight == 0) || (exp_q[0].ctl == m_cur);
  endfunction

  function automatic bit model_bypass();
`ifdef DUMMY_ACC_ISSUE_BYPASS_EN
    return (exp_q.size() == 0) && valid_i && (m_inflight < MAX_INFLIGHT) &&
           ((m_inflight == 0) || (ctl_i == m_cur));
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_tick();
    bit byp, fire, was_full;
    int dec;
    m_entry_t e;
    if (rst_i) begin
      exp_q.delete(); m_inflight = 0; m_cur = EU_CTL_ITERATIVE;
    end else if (flush_i) begin
      exp_q.delete(); m_inflight = 0;
    end else begin
      byp      = model_bypass();
      fire     = (model_elig() || byp) && acc_ready_i;
      was_full = (exp_q.size() == DEPTH);
      dec      = (acc_done_i && m_inflight > 0) ? 1 : 0;
      if (fire) begin
        if (byp) m_cur = ctl_i;
        else begin m_cur = exp_q[0].ctl; void'(exp_q.pop_front()); end
      end
      if (valid_i && !was_full && !(byp && fire)) begin
        e.ctl = ctl_i; e.rs1 = rs1_value_i; e.imm = imm_i; e.tag = tag_i;
        exp_q.push_back(e);
      end
      m_inflight = m_inflight + (fire ? 1 : 0) - dec;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic idle_inputs();
    rst_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ctl_i = EU_CTL_ITERATIVE;
    rs1_value_i = '0; imm_i = '0; tag_i = '0; acc_ready_i = 1'b0; acc_done_i = 1'b0;
  endtask

  task automatic push_req(input ctl_type_t c, input int t);
    valid_i = 1'b1; ctl_i = c; tag_i = TAG_WIDTH'(t);
    rs1_value_i = WIDTH'(t * 1000 + 7); imm_i = IMM_WIDTH'(t + 3);
    tick();
    valid_i = 1'b0;
  endtask

  task automatic done_pulses(input int n);
    acc_done_i = 1'b1;
    for (int i = 0; i < n; i++) tick();
    acc_done_i = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    if (ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got=%0b exp=1", ready_o); end
    tests++;
    if (acc_valid_o !== 1'b0) begin fails++; $display("FAIL reset_acc_valid got=%0b exp=0", acc_valid_o); end
    tests++;
    if (empty_o !== 1'b1 || full_o !== 1'b0) begin
      fails++; $display("FAIL reset_empty_full got=%0b%0b exp=10", empty_o, full_o);
    end
    tests++;
    if (inflight_o !== '0) begin fails++; $display("FAIL reset_inflight got=%0d exp=0", inflight_o); end
    tests++;
    if (acc_rs1_value_o !== '0 || acc_tag_o !== '0 || acc_imm_o !== '0) begin
      fails++; $display("FAIL reset_acc_data got=%h/%h/%h exp=0", acc_rs1_value_o, acc_imm_o, acc_tag_o);
    end
    tests++;
    if (state_o !== S_IDLE) begin fails++; $display("FAIL reset_state got=%0d exp=%0d", state_o, S_IDLE); end
    tests++;
  endtask

  task automatic test_fill();
    idle_inputs();
    for (int t = 1; t <= 4; t++) push_req(EU_CTL_ITERATIVE, t);
    if (full_o !== 1'b1 || ready_o !== 1'b0) begin
      fails++; $display("FAIL fill_full got full=%0b ready=%0b exp full=1 ready=0", full_o, ready_o);
    end
    tests++;
    push_req(EU_CTL_ITERATIVE, 5);
    if (full_o !== 1'b1 || acc_valid_o !== 1'b1 || acc_tag_o !== 5'd1) begin
      fails++; $display("FAIL fill_fifth got full=%0b valid=%0b tag=%0d exp 1/1/1", full_o, acc_valid_o, acc_tag_o);
    end
    tests++;
  endtask

  task automatic test_drain();
    idle_inputs();
    acc_ready_i = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      if (acc_valid_o !== 1'b1 || acc_tag_o !== TAG_WIDTH'(t) || acc_rs1_value_o !== WIDTH'(t * 1000 + 7)) begin
        fails++; $display("FAIL drain_order got valid=%0b tag=%0d rs1=%0d exp valid=1 tag=%0d rs1=%0d",
                          acc_valid_o, acc_tag_o, acc_rs1_value_o, t, t * 1000 + 7);
      end
      tests++;
      tick();
    end
    if (inflight_o !== IW'(4) || empty_o !== 1'b1 || acc_valid_o !== 1'b0) begin
      fails++; $display("FAIL drain_end got inflight=%0d empty=%0b valid=%0b exp 4/1/0", inflight_o, empty_o, acc_valid_o);
    end
    tests++;
    acc_ready_i = 1'b0;
    done_pulses(4);
    if (inflight_o !== '0 || state_o !== S_IDLE) begin
      fails++; $display("FAIL drain_done got inflight=%0d state=%0d exp 0/%0d", inflight_o, state_o, S_IDLE);
    end
    tests++;
  endtask

  task automatic test_mixed_ctl();
    idle_inputs();
    push_req(EU_CTL_ITERATIVE, 1);
    push_req(EU_CTL_PIPELINE, 2);
    acc_ready_i = 1'b1;
    if (acc_valid_o !== 1'b1 || acc_tag_o !== 5'd1) begin
      fails++; $display("FAIL mixed_first got valid=%0b tag=%0d exp 1/1", acc_valid_o, acc_tag_o);
    end
    tests++;
    tick();
    for (int k = 0; k < 3; k++) begin
      if (acc_valid_o !== 1'b0) begin fails++; $display("FAIL mixed_blocked cyc=%0d got=%0b exp=0", k, acc_valid_o); end
      tests++;
      tick();
    end
    if (state_o !== S_DRAIN) begin fails++; $display("FAIL mixed_drain_state got=%0d exp=%0d", state_o, S_DRAIN); end
    tests++;
    done_pulses(1);
    if (acc_valid_o !== 1'b1 || acc_ctl_o !== EU_CTL_PIPELINE || acc_tag_o !== 5'd2 || inflight_o !== '0) begin
      fails++; $display("FAIL mixed_second got valid=%0b ctl=%0d tag=%0d inflight=%0d exp 1/1/2/0",
                        acc_valid_o, acc_ctl_o, acc_tag_o, inflight_o);
    end
    tests++;
    tick();
    if (inflight_o !== IW'(1) || acc_valid_o !== 1'b0) begin
      fails++; $display("FAIL mixed_issued got inflight=%0d valid=%0b exp 1/0", inflight_o, acc_valid_o);
    end
    tests++;
    acc_ready_i = 1'b0;
    done_pulses(1);
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    for (int t = 1; t <= 4; t++) push_req(EU_CTL_ITERATIVE, t);
    acc_ready_i = 1'b1;
    tick(); tick(); tick();
    if (inflight_o !== IW'(3)) begin fails++; $display("FAIL b2b_inflight3 got=%0d exp=3", inflight_o); end
    tests++;
    acc_done_i = 1'b1;
    tick();
    if (inflight_o !== IW'(3) || empty_o !== 1'b1) begin
      fails++; $display("FAIL fire_and_done got inflight=%0d empty=%0b exp 3/1", inflight_o, empty_o);
    end
    tests++;
    acc_ready_i = 1'b0;
    done_pulses(3);
    if (inflight_o !== '0) begin fails++; $display("FAIL b2b_drained got=%0d exp=0", inflight_o); end
    tests++;
    done_pulses(1);
    if (inflight_o !== '0) begin fails++; $display("FAIL spurious_done got=%0d exp=0", inflight_o); end
    tests++;
  endtask

  task automatic test_flush();
    idle_inputs();
    push_req(EU_CTL_ITERATIVE, 1);
    push_req(EU_CTL_ITERATIVE, 2);
    acc_ready_i = 1'b1;
    tick(); tick();
    acc_ready_i = 1'b0;
    for (int t = 3; t <= 5; t++) push_req(EU_CTL_ITERATIVE, t);
    if (inflight_o !== IW'(2) || empty_o !== 1'b0) begin
      fails++; $display("FAIL flush_setup got inflight=%0d empty=%0b exp 2/0", inflight_o, empty_o);
    end
    tests++;
    flush_i = 1'b1; valid_i = 1'b1; tag_i = 5'd9; acc_ready_i = 1'b1;
    tick();
    idle_inputs();
    if (empty_o !== 1'b1 || inflight_o !== '0 || state_o !== S_IDLE || acc_valid_o !== 1'b0) begin
      fails++; $display("FAIL flush_clear got empty=%0b inflight=%0d state=%0d valid=%0b exp 1/0/0/0",
                        empty_o, inflight_o, state_o, acc_valid_o);
    end
    tests++;
    tick(); tick();
    done_pulses(1);
    if (empty_o !== 1'b1 || inflight_o !== '0) begin
      fails++; $display("FAIL flush_dropped got empty=%0b inflight=%0d exp 1/0", empty_o, inflight_o);
    end
    tests++;
  endtask

`ifdef DUMMY_ACC_ISSUE_BYPASS_EN
  task automatic test_bypass();
    idle_inputs();
    acc_ready_i = 1'b1; valid_i = 1'b1; ctl_i = EU_CTL_PIPELINE; tag_i = 5'd7;
    #1;
    if (acc_valid_o !== 1'b1 || acc_tag_o !== 5'd7 || acc_ctl_o !== EU_CTL_PIPELINE) begin
      fails++; $display("FAIL bypass_same_cycle got valid=%0b tag=%0d exp 1/7", acc_valid_o, acc_tag_o);
    end
    tests++;
    tick();
    idle_inputs();
    if (empty_o !== 1'b1 || inflight_o !== IW'(1)) begin
      fails++; $display("FAIL bypass_no_write got empty=%0b inflight=%0d exp 1/1", empty_o, inflight_o);
    end
    tests++;
    done_pulses(1);
  endtask
`endif

  task automatic test_random();
    logic [3+IW-1:0]  exp_st, got_st;
    logic [WIDTH+IMM_WIDTH+TAG_WIDTH:0] exp_d, got_d;
    bit exp_v, byp;
    int done_pct;
    idle_inputs();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      done_pct = (i < 1000) ? 25 : ((i < 2000) ? 70 : 10);
      valid_i     = ($urandom_range(0, 1) == 1);
      ctl_i       = ($urandom_range(0, 3) == 0) ? EU_CTL_PIPELINE : ((i % 7 == 0) ? EU_CTL_PIPELINE : EU_CTL_ITERATIVE);
      rs1_value_i = $urandom;
      imm_i       = IMM_WIDTH'($urandom_range(0, 2047));
      tag_i       = TAG_WIDTH'($urandom_range(0, 31));
      acc_ready_i = ($urandom_range(0, 9) < 6);
      acc_done_i  = ($urandom_range(0, 99) < done_pct);
      flush_i     = ($urandom_range(0, 199) == 0);
      @(negedge clk);
      byp    = model_bypass();
      exp_v  = model_elig() || byp;
      exp_st = {exp_q.size() < DEPTH, exp_q.size() == DEPTH, exp_q.size() == 0, exp_v, IW'(m_inflight)};
      got_st = {ready_o, full_o, empty_o, acc_valid_o, inflight_o};
      if (got_st !== exp_st) begin
        fails++; $display("FAIL rand_status cyc=%0d got rdy/full/empty/valid/infl=%b exp=%b", i, got_st, exp_st);
      end
      tests++;
      if (exp_v) begin
        if (byp) exp_d = {ctl_i, rs1_value_i, imm_i, tag_i};
        else     exp_d = {exp_q[0].ctl, exp_q[0].rs1, exp_q[0].imm, exp_q[0].tag};
        got_d = {acc_ctl_o, acc_rs1_value_o, acc_imm_o, acc_tag_o};
        if (got_d !== exp_d) begin
          fails++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", i, got_d, exp_d);
        end
        tests++;
      end
      tick();
    end
    idle_inputs();
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    idle_inputs();
    rst_i = 1'b1;
    test_reset();
    test_fill();
    test_drain();
    test_mixed_ctl();
    test_back_to_back();
    test_flush();
`ifdef DUMMY_ACC_ISSUE_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
